uart_bus_master: RTL and testbench
==================================

Name: uart_bus_master

Overview:
- UART-to-bus bridge: the initiator end of the peripheral register interface, driven by a host PC over 8N1 serial.
- Decodes read and write command frames received on rx_pin, issues single-word bus accesses, and returns a response frame on tx_pin.
- Sits beside the core as a second bus master for program download and debug register poking.

Parameters:
- CLK_DIV, 434: clock cycles per UART bit (50 MHz / 115200).
- TIMEOUT_CYCLES, 500000: inter-byte timeout inside a frame (10 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- rx_pin  in  1  serial in from host, idle high
- tx_pin  out  1  serial out to host, idle high
- req_o  out  1  bus request
- we_o  out  1  1 = write, 0 = read; valid while req_o is high
- addr_o  out  32  bus address
- data_o  out  32  bus write data
- data_i  in  32  bus read data, valid in the gnt_i cycle
- gnt_i  in  1  bus grant/complete, single-cycle sample
- busy_o  out  1  frame in progress (any state other than S_CMD, or TX active)

Behaviour:
- Reset is asynchronous: every register clears immediately, including mid-frame or mid-access.
  - Reset values: tx_pin=1, req_o=0, we_o=0, addr_o=0, data_o=0, busy_o=0; FSM enters S_CMD.
- RX path:
  - rx_pin passes through a 2-FF synchronizer.
  - A falling edge while RX is idle starts a byte.
  - The start bit is re-sampled at CLK_DIV/2; if it reads 1, this is a glitch and RX returns to idle.
  - Data bits are sampled every CLK_DIV cycles after that, LSB first.
  - The stop bit is sampled; if it reads 0, this is a framing error: the byte is discarded and the frame FSM aborts to S_CMD with no response.
  - A good byte gives a one-cycle rx_valid pulse with rx_byte.
- Frame format (multi-byte fields LSB first):
  - Write: 0x57, A0..A3, D0..D3.
  - Read: 0x52, A0..A3.
- FSM:
  - S_CMD: byte 0x57 or 0x52 latches the op and goes to S_ADDR. Any other byte queues response 0x45 and goes to S_RESP.
  - S_ADDR: collects 4 bytes into addr_o[8k+7:8k] via a 2-bit byte counter. After the 4th byte, a write goes to S_DATA and a read goes to S_BUS.
  - S_DATA: collects 4 bytes into data_o, then goes to S_BUS.
  - S_BUS: req_o=1, we_o=op, addr_o and data_o held stable. The first posedge with gnt_i=1 completes the access:
    - For a read, data_i is latched into the response shift register.
    - req_o and we_o are 0 the next cycle.
    - Then go to S_RESP.
    - With gnt_i already high, req_o is high for exactly 1 cycle.
    - There is no bus timeout; a hung bus holds S_BUS.
  - S_RESP: transmits the response bytes back-to-back, then returns to S_CMD.
    - Write: 0x4B.
    - Read: 4 bytes, LSB first.
    - Error: 0x45.
- RX bytes arriving in S_BUS or S_RESP are discarded.
- TX path: 8N1, start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly CLK_DIV cycles.
- A new response byte starts the cycle after the previous byte's stop bit ends. No idle gap is required.
- addr_o and data_o keep their last values after the frame completes.

Optional Feature:
- Macro: UART_BUS_MASTER_TIMEOUT_EN.
- Defined:
  - A counter is cleared at every rx_valid and counts while in S_ADDR or S_DATA.
  - When it reaches TIMEOUT_CYCLES, the FSM returns to S_CMD with no response and no bus access; the partial addr_o/data_o contents are kept.
- Undefined: no counter; the FSM waits indefinitely for the remaining bytes.

Decomposition:
- Shared header holds the constants:
  - command codes CMD_WR=8'h57, CMD_RD=8'h52;
  - response codes RSP_OK=8'h4B, RSP_ERR=8'h45;
  - one-hot FSM state encodings.
- One sub-module: uart_byte_rx. It contains the synchronizer, start detection, bit sampling and stop check; it outputs rx_valid, rx_byte and frame_err (one-cycle pulse).
- The TX serializer and the frame FSM stay inline.

Test Plan (CLK_DIV=16, TIMEOUT_CYCLES=2000):
- Write frame 57 10 00 00 10 EF BE AD DE, gnt_i held 1 -> one req_o/we_o=1 pulse with addr_o=0x10000010, data_o=0xDEADBEEF; then tx_pin carries 0x4B.
- Read frame 52 04 00 00 10, gnt_i asserted 3 cycles after req_o, data_i=0x12345678 -> req_o high 4 cycles, we_o=0; tx_pin carries 78 56 34 12.
- Byte 0x41 in S_CMD -> no req_o; tx_pin carries 0x45; FSM back in S_CMD (busy_o=0).
- Write frame with the stop bit of A2 forced to 0 -> no req_o and no TX; a following valid read frame completes normally.
- With UART_BUS_MASTER_TIMEOUT_EN: send 52 04 00, then idle 2500 cycles -> no req_o, busy_o=0; a fresh frame then succeeds. Without the macro: busy_o stays 1.
- Assert rst low for 1 cycle during S_BUS -> req_o=0, tx_pin=1, addr_o=0 immediately; the next frame is decoded from S_CMD.

Source files
------------

// File: rtl/uart_bus_master_pkg.sv
// Shared constants and types for the UART-to-bus bridge.
//   - Command codes the host sends: CMD_WR, CMD_RD.
//   - Response codes returned to the host: RSP_OK, RSP_ERR.
//   - One-hot frame FSM encoding and the byte receiver state type.
package uart_bus_master_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'

  typedef enum logic [4:0] {
    S_CMD  = 5'b00001,
    S_ADDR = 5'b00010,
    S_DATA = 5'b00100,
    S_BUS  = 5'b01000,
    S_RESP = 5'b10000
  } frame_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver.
// Synchronizes rx_pin, detects the falling edge of a start bit, re-checks the
// start bit half a bit later (glitch rejection), samples 8 data bits LSB first
// one bit period apart, then checks the stop bit.
// Ports:
//   clk, rst       system clock, asynchronous active-low reset
//   rx_pin         raw serial input, idle high
//   rx_valid       one-cycle pulse, rx_byte holds a good byte
//   rx_byte        last received byte (stable until the next byte starts)
//   frame_err      one-cycle pulse when the stop bit reads 0 (byte discarded)
module uart_byte_rx
  import uart_bus_master_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam logic [15:0] FULL_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

  rx_state_t   state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic        prev_q, prev_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        rx_sync;

  assign rx_sync   = sync_q[1];
  assign rx_valid  = valid_q;
  assign rx_byte   = shift_q;
  assign frame_err = err_q;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    sync_d  = {sync_q[0], rx_pin};
    prev_d  = rx_sync;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (prev_q && !rx_sync) state_d = RX_START;
      end
      RX_START: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          // A start bit that is high again at mid-bit was a glitch.
          state_d = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == FULL_LAST) begin
          // Leaving at mid-stop-bit lets the next start edge be caught on time.
          state_d = RX_IDLE;
          valid_d = rx_sync;
          err_d   = !rx_sync;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RX_IDLE;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// UART-to-bus bridge: host-driven second bus master for download and debug.
// Frames (LSB first): write = 57 A0..A3 D0..D3, read = 52 A0..A3.
// Responses: write -> 4B, read -> 4 data bytes, unknown command -> 45.
// Build option: define UART_BUS_MASTER_TIMEOUT_EN to abandon a frame whose
// next byte does not arrive within TIMEOUT_CYCLES while collecting addr/data.
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   rx_pin, tx_pin  8N1 serial from / to host, idle high
//   req_o, we_o     bus request and direction (1 = write)
//   addr_o, data_o  bus address and write data, held after the frame
//   data_i, gnt_i   bus read data and single-cycle grant/complete
//   busy_o          frame in progress or response still transmitting
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int CLK_DIV        = 434,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_pin,
  output logic        tx_pin,
  output logic        req_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  input  logic [31:0] data_i,
  input  logic        gnt_i,
  output logic        busy_o
);

  localparam logic [15:0] FULL_LAST = 16'(CLK_DIV - 1);

  logic       rx_valid, frame_err;
  logic [7:0] rx_byte;

  uart_byte_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_pin    (rx_pin),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  frame_state_t state_q, state_d;
  logic [1:0]   byte_cnt_q, byte_cnt_d;
  logic         op_we_q, op_we_d;
  logic         req_q, req_d;
  logic         we_q, we_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  data_q, data_d;
  logic [31:0]  rsp_q, rsp_d;
  logic [2:0]   rsp_left_q, rsp_left_d;
  logic         tx_active_q, tx_active_d;
  logic [15:0]  tx_cnt_q, tx_cnt_d;
  logic [3:0]   tx_bit_q, tx_bit_d;
  logic [9:0]   tx_frame_q, tx_frame_d;
  logic         tx_done;
  logic         tx_free;
  logic         timeout_hit;

`ifdef UART_BUS_MASTER_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = '0;
    if (state_q == S_ADDR || state_q == S_DATA)
      to_cnt_d = rx_valid ? 32'd0 : to_cnt_q + 32'd1;
  end

  assign timeout_hit = (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_cnt_q <= '0;
    else      to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // tx_frame_q[0] is the line itself; the frame shifts right filling with 1s,
  // so the line returns to idle on its own after the stop bit.
  assign tx_pin = tx_frame_q[0];
  assign req_o  = req_q;
  assign we_o   = we_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign busy_o = (state_q != S_CMD) || tx_active_q;

  assign tx_done = tx_active_q && (tx_cnt_q == FULL_LAST) && (tx_bit_q == 4'd9);
  // The serializer can take a new byte in the same cycle the stop bit ends.
  assign tx_free = !tx_active_q || tx_done;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    op_we_d     = op_we_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rsp_d       = rsp_q;
    rsp_left_d  = rsp_left_q;
    tx_active_d = tx_active_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_frame_d  = tx_frame_q;

    // Serializer: bit 0 is the start bit, bit 9 the stop bit.
    if (tx_active_q) begin
      tx_cnt_d = tx_cnt_q + 16'd1;
      if (tx_cnt_q == FULL_LAST) begin
        tx_cnt_d   = '0;
        tx_frame_d = {1'b1, tx_frame_q[9:1]};
        tx_bit_d   = tx_bit_q + 4'd1;
        if (tx_bit_q == 4'd9) begin
          tx_active_d = 1'b0;
          tx_bit_d    = '0;
        end
      end
    end

    unique case (state_q)
      S_CMD: begin
        if (rx_valid) begin
          if (rx_byte == CMD_WR || rx_byte == CMD_RD) begin
            op_we_d    = (rx_byte == CMD_WR);
            byte_cnt_d = '0;
            state_d    = S_ADDR;
          end else begin
            rsp_d      = {24'd0, RSP_ERR};
            rsp_left_d = 3'd1;
            state_d    = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (frame_err) begin
          state_d = S_CMD;
        end else if (rx_valid) begin
          addr_d[{byte_cnt_q, 3'b000} +: 8] = rx_byte;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (op_we_q) begin
              state_d = S_DATA;
            end else begin
              state_d = S_BUS;
              req_d   = 1'b1;
              we_d    = 1'b0;
            end
          end
        end else if (timeout_hit) begin
          state_d = S_CMD;
        end
      end
      S_DATA: begin
        if (frame_err) begin
          state_d = S_CMD;
        end else if (rx_valid) begin
          data_d[{byte_cnt_q, 3'b000} +: 8] = rx_byte;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_BUS;
            req_d   = 1'b1;
            we_d    = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = S_CMD;
        end
      end
      S_BUS: begin
        if (gnt_i) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_RESP;
          if (op_we_q) begin
            rsp_d      = {24'd0, RSP_OK};
            rsp_left_d = 3'd1;
          end else begin
            rsp_d      = data_i;
            rsp_left_d = 3'd4;
          end
        end
      end
      S_RESP: begin
        if (tx_free) begin
          if (rsp_left_q != 3'd0) begin
            tx_frame_d  = {1'b1, rsp_q[7:0], 1'b0};
            tx_active_d = 1'b1;
            tx_cnt_d    = '0;
            tx_bit_d    = '0;
            rsp_d       = rsp_q >> 8;
            rsp_left_d  = rsp_left_q - 3'd1;
          end else begin
            state_d = S_CMD;
          end
        end
      end
      default: state_d = S_CMD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_CMD;
      byte_cnt_q  <= '0;
      op_we_q     <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_q       <= '0;
      rsp_left_q  <= '0;
      tx_active_q <= 1'b0;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_frame_q  <= '1;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      op_we_q     <= op_we_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_q       <= rsp_d;
      rsp_left_q  <= rsp_left_d;
      tx_active_q <= tx_active_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_frame_q  <= tx_frame_d;
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master with CLK_DIV=16, TIMEOUT_CYCLES=2000.
// A background UART receiver decodes tx_pin into a byte queue, a bus monitor
// records request cycles and the address/data/direction seen while req_o is
// high, and a grant responder answers requests in one of three modes.
module tb_uart_bus_master;

  localparam int CLK_DIV = 16;
  localparam int TO_CYC  = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_pin = 1'b1;
  logic        tx_pin;
  logic        req_o, we_o, busy_o;
  logic [31:0] addr_o, data_o;
  logic [31:0] data_i = '0;
  logic        gnt_i = 1'b0;

  int checks = 0;
  int errors = 0;

  uart_bus_master #(.CLK_DIV(CLK_DIV), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk    (clk),
    .rst    (rst),
    .rx_pin (rx_pin),
    .tx_pin (tx_pin),
    .req_o  (req_o),
    .we_o   (we_o),
    .addr_o (addr_o),
    .data_o (data_o),
    .data_i (data_i),
    .gnt_i  (gnt_i),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // UART receiver on tx_pin.
  logic [7:0] txq[$];
  int         tx_stop_bad = 0;
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx_pin === 1'b0) begin
        repeat (CLK_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          b[i] = tx_pin;
        end
        repeat (CLK_DIV) @(negedge clk);
        if (tx_pin !== 1'b1) tx_stop_bad++;
        txq.push_back(b);
      end
    end
  end

  // Bus monitor.
  int          req_cycles = 0;
  int          req_rises  = 0;
  logic        prev_req   = 1'b0;
  logic        seen_we    = 1'b0;
  logic [31:0] seen_addr  = '0;
  logic [31:0] seen_data  = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (req_o === 1'b1) begin
        req_cycles++;
        if (!prev_req) req_rises++;
        seen_we   = we_o;
        seen_addr = addr_o;
        seen_data = data_o;
      end
      prev_req = (req_o === 1'b1);
    end
  end

  // Grant responder: 0 = never, 1 = held high, 2 = high in the 4th req cycle.
  int gnt_mode = 0;
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      case (gnt_mode)
        1: gnt_i = 1'b1;
        2: begin
          if (req_o === 1'b1) begin
            cnt++;
            gnt_i = (cnt == 4);
          end else begin
            cnt   = 0;
            gnt_i = 1'b0;
          end
        end
        default: gnt_i = 1'b0;
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    req_cycles = 0;
    req_rises  = 0;
    txq.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx_pin = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx_pin = stop_bit;
    repeat (CLK_DIV) @(negedge clk);
    rx_pin = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    foreach (f[i]) send_byte(f[i], 1'b1);
  endtask

  task automatic wait_tx(input string tag, input int n, input int budget);
    for (int c = 0; c < budget && txq.size() < n; c++) @(negedge clk);
    check(tag, txq.size(), n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] fr[$];

    // Reset state.
    idle(3);
    check("rst_tx_pin", tx_pin, 1);
    check("rst_req", req_o, 0);
    check("rst_we", we_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_data", data_o, 0);
    check("rst_busy", busy_o, 0);
    rst = 1'b1;
    idle(5);

    // Write with grant already high: one single-cycle request.
    gnt_mode = 1;
    clear_mon();
    fr = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h10, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame(fr);
    wait_tx("wr_tx_count", 1, 2000);
    check("wr_req_rises", req_rises, 1);
    check("wr_req_cycles", req_cycles, 1);
    check("wr_we", seen_we, 1);
    check("wr_addr", seen_addr, 32'h1000_0010);
    check("wr_data", seen_data, 32'hDEAD_BEEF);
    check("wr_rsp", txq[0], 8'h4B);
    idle(20);
    check("wr_busy_after", busy_o, 0);
    check("wr_addr_held", addr_o, 32'h1000_0010);

    // Read with grant in the 4th request cycle.
    gnt_mode = 2;
    data_i   = 32'h1234_5678;
    clear_mon();
    fr = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h10};
    send_frame(fr);
    wait_tx("rd_tx_count", 4, 3000);
    check("rd_req_cycles", req_cycles, 4);
    check("rd_we", seen_we, 0);
    check("rd_addr", seen_addr, 32'h1000_0004);
    check("rd_rsp0", txq[0], 8'h78);
    check("rd_rsp1", txq[1], 8'h56);
    check("rd_rsp2", txq[2], 8'h34);
    check("rd_rsp3", txq[3], 8'h12);

    // Unknown command.
    gnt_mode = 1;
    clear_mon();
    send_byte(8'h41, 1'b1);
    wait_tx("err_tx_count", 1, 1000);
    check("err_rsp", txq[0], 8'h45);
    check("err_no_req", req_rises, 0);
    idle(20);
    check("err_busy", busy_o, 0);

    // Framing error on A2 aborts silently.
    clear_mon();
    send_byte(8'h57, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);
    idle(400);
    check("ferr_no_req", req_rises, 0);
    check("ferr_no_tx", txq.size(), 0);
    check("ferr_busy", busy_o, 0);
    data_i = 32'hCAFE_F00D;
    fr = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h20};
    send_frame(fr);
    wait_tx("ferr_rd_tx_count", 4, 2000);
    check("ferr_rd_addr", seen_addr, 32'h2000_0000);
    check("ferr_rd_rsp0", txq[0], 8'h0D);
    check("ferr_rd_rsp3", txq[3], 8'hCA);

    // Partial frame followed by a long silence.
    clear_mon();
    fr = '{8'h52, 8'h04, 8'h00};
    send_frame(fr);
    idle(2500);
    check("to_no_req", req_rises, 0);
`ifdef UART_BUS_MASTER_TIMEOUT_EN
    check("to_busy", busy_o, 0);
    data_i = 32'h0BAD_CAFE;
    fr = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h30};
    send_frame(fr);
    wait_tx("to_next_tx_count", 4, 2000);
    check("to_next_addr", seen_addr, 32'h3000_0008);
    check("to_next_rsp0", txq[0], 8'hFE);
`else
    check("to_busy", busy_o, 1);
    data_i = 32'h0BAD_CAFE;
    fr = '{8'h00, 8'h10};
    send_frame(fr);
    wait_tx("to_rest_tx_count", 4, 2000);
    check("to_rest_addr", seen_addr, 32'h1000_0004);
    check("to_rest_rsp0", txq[0], 8'hFE);
`endif

    // Reset while the bus access is pending.
    gnt_mode = 0;
    idle(20);
    clear_mon();
    fr = '{8'h57, 8'h44, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    send_frame(fr);
    for (int c = 0; c < 200 && req_o !== 1'b1; c++) @(negedge clk);
    check("rstbus_req_pending", req_o, 1);
    rst = 1'b0;
    #1;
    check("rstbus_req", req_o, 0);
    check("rstbus_tx_pin", tx_pin, 1);
    check("rstbus_addr", addr_o, 0);
    check("rstbus_busy", busy_o, 0);
    @(negedge clk);
    rst = 1'b1;
    gnt_mode = 1;
    idle(5);
    clear_mon();
    data_i = 32'h55AA_33CC;
    fr = '{8'h52, 8'h0C, 8'h00, 8'h00, 8'h40};
    send_frame(fr);
    wait_tx("rstbus_rd_tx_count", 4, 2000);
    check("rstbus_rd_rises", req_rises, 1);
    check("rstbus_rd_addr", seen_addr, 32'h4000_000C);
    check("rstbus_rd_rsp0", txq[0], 8'hCC);
    check("rstbus_rd_rsp1", txq[1], 8'h33);
    check("rstbus_rd_rsp2", txq[2], 8'hAA);
    check("rstbus_rd_rsp3", txq[3], 8'h55);

    check("tx_stop_bits", tx_stop_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
